// File: rtl/g_code_pkg.sv
// Shared definitions for the G-code value path: ASCII codes, field indices,
// converter state encoding and a small power-of-ten helper.
package g_code_pkg;

  localparam logic [7:0] ASCII_NUL   = 8'd0;
  localparam logic [7:0] ASCII_DOT   = 8'd46;
  localparam logic [7:0] ASCII_ZERO  = 8'd48;
  localparam logic [7:0] ASCII_NINE  = 8'd57;
  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_MINUS = 8'd45;

  localparam logic [2:0] FIELD_F = 3'd0;
  localparam logic [2:0] FIELD_X = 3'd1;
  localparam logic [2:0] FIELD_Y = 3'd2;
  localparam logic [2:0] FIELD_Z = 3'd3;
  localparam logic [2:0] FIELD_E = 3'd4;

  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SCALE = 2'd2
  } conv_state_e;

  function automatic logic [31:0] pow10(input logic [1:0] n);
    case (n)
      2'd0:    pow10 = 32'd1;
      2'd1:    pow10 = 32'd10;
      2'd2:    pow10 = 32'd100;
      default: pow10 = 32'd1000;
    endcase
  endfunction

endpackage

// File: rtl/g_code_value_converter_ascii_char_classifier.sv
// Combinational ASCII byte classifier: splits a byte into digit / dot / NUL /
// anything-else, and yields the decimal value of a digit.
module ascii_char_classifier (
  input  logic [7:0] byte_i,
  output logic       is_digit_o,
  output logic [3:0] digit_o,
  output logic       is_dot_o,
  output logic       is_nul_o,
  output logic       is_bad_o
);
  import g_code_pkg::*;

  // Classify the byte; '0'..'9' are 0x30..0x39 so the low nibble is the digit
  always_comb begin
    is_digit_o = (byte_i >= ASCII_ZERO) && (byte_i <= ASCII_NINE);
    if (is_digit_o) begin
      digit_o = byte_i[3:0];
    end else begin
      digit_o = 4'd0;
    end
    is_dot_o = (byte_i == ASCII_DOT);
    is_nul_o = (byte_i == ASCII_NUL);
    is_bad_o = !(is_digit_o || is_dot_o || is_nul_o);
  end

endmodule

// File: rtl/g_code_value_converter.sv
// Converts the five packed-ASCII operand words of a decoded G-code line into
// unsigned fixed-point milli-units, publishing all results atomically.
module g_code_value_converter #(
  parameter int unsigned FRAC_DIGITS = 3
) (
  input  logic        i_Clock50MHz,
  input  logic        i_Reset,
  input  logic        i_LineComplete,
  input  logic [47:0] i_FValue,
  input  logic [47:0] i_XValue,
  input  logic [47:0] i_YValue,
  input  logic [47:0] i_ZValue,
  input  logic [47:0] i_EValue,
  input  logic        i_XDirection,
  input  logic        i_YDirection,
  input  logic        i_ZDirection,
  input  logic        i_EDirection,
  output logic [31:0] o_FFixed,
  output logic [31:0] o_XFixed,
  output logic [31:0] o_YFixed,
  output logic [31:0] o_ZFixed,
  output logic [31:0] o_EFixed,
  output logic        o_XDirection,
  output logic        o_YDirection,
  output logic        o_ZDirection,
  output logic        o_EDirection,
  output logic        o_Valid,
  output logic        o_Busy,
  output logic [4:0]  o_Error,
  output logic        o_Overrun
);
  import g_code_pkg::*;

  if (FRAC_DIGITS > 3) begin : g_frac_digits_check
    $error("g_code_value_converter: FRAC_DIGITS must be in 0..3");
  end

  localparam logic [1:0] FRAC_W = 2'(FRAC_DIGITS);

  conv_state_e       state_q;
  logic [2:0]        byte_idx_q;
  logic [2:0]        field_idx_q;
  logic [4:0][47:0]  words_q;
  logic [3:0]        dir_q;
  logic [31:0]       acc_q;
  logic [1:0]        frac_cnt_q;
  logic              dot_q;
  logic              err_q;
  logic [3:0][31:0]  shadow_q;
  logic [3:0]        shadow_err_q;
  logic              lc_prev_q;

  logic [31:0] acc_d;
  logic [1:0]  frac_cnt_d;
  logic        dot_d;
  logic        err_d;

  logic        rise_s;
  logic [47:0] word_s;
  logic [7:0]  byte_s;
  logic [31:0] scaled_s;
  logic        is_digit_s;
  logic [3:0]  digit_s;
  logic        is_dot_s;
  logic        is_nul_s;
  logic        is_bad_s;

  assign rise_s = i_LineComplete & ~lc_prev_q;

  // Select the byte under the scan pointer, oldest (MSB) byte first
  always_comb begin
    case (field_idx_q)
      FIELD_F: word_s = words_q[0];
      FIELD_X: word_s = words_q[1];
      FIELD_Y: word_s = words_q[2];
      FIELD_Z: word_s = words_q[3];
      FIELD_E: word_s = words_q[4];
      default: word_s = 48'd0;
    endcase
    case (byte_idx_q)
      3'd0:    byte_s = word_s[47:40];
      3'd1:    byte_s = word_s[39:32];
      3'd2:    byte_s = word_s[31:24];
      3'd3:    byte_s = word_s[23:16];
      3'd4:    byte_s = word_s[15:8];
      3'd5:    byte_s = word_s[7:0];
      default: byte_s = 8'd0;
    endcase
  end

  ascii_char_classifier u_classifier (
    .byte_i     (byte_s),
    .is_digit_o (is_digit_s),
    .digit_o    (digit_s),
    .is_dot_o   (is_dot_s),
    .is_nul_o   (is_nul_s),
    .is_bad_o   (is_bad_s)
  );

  // Accumulator step for one scanned byte; surplus fraction digits truncate
  always_comb begin
    acc_d      = acc_q;
    frac_cnt_d = frac_cnt_q;
    dot_d      = dot_q;
    err_d      = err_q;
    if (is_nul_s) begin
      acc_d = acc_q;
    end else if (is_digit_s) begin
      if (!dot_q) begin
        acc_d = acc_q * 32'd10 + {28'd0, digit_s};
      end else if (frac_cnt_q < FRAC_W) begin
        acc_d      = acc_q * 32'd10 + {28'd0, digit_s};
        frac_cnt_d = frac_cnt_q + 2'd1;
      end else begin
        acc_d = acc_q;
      end
    end else if (is_dot_s) begin
      if (dot_q) begin
        err_d = 1'b1;
      end else begin
        dot_d = 1'b1;
      end
    end else if (is_bad_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Pad missing fraction digits with zeros; a syntax error forces zero
  always_comb begin
    if (err_q) begin
      scaled_s = 32'd0;
    end else begin
      scaled_s = acc_q * pow10(FRAC_W - frac_cnt_q);
    end
  end

  // Conversion FSM with registered, atomically published results
  always_ff @(posedge i_Clock50MHz or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 3'd0;
      field_idx_q  <= 3'd0;
      words_q      <= '0;
      dir_q        <= 4'd0;
      acc_q        <= 32'd0;
      frac_cnt_q   <= 2'd0;
      dot_q        <= 1'b0;
      err_q        <= 1'b0;
      shadow_q     <= '0;
      shadow_err_q <= 4'd0;
      lc_prev_q    <= 1'b0;
      o_FFixed     <= 32'd0;
      o_XFixed     <= 32'd0;
      o_YFixed     <= 32'd0;
      o_ZFixed     <= 32'd0;
      o_EFixed     <= 32'd0;
      o_XDirection <= 1'b0;
      o_YDirection <= 1'b0;
      o_ZDirection <= 1'b0;
      o_EDirection <= 1'b0;
      o_Valid      <= 1'b0;
      o_Busy       <= 1'b0;
      o_Error      <= 5'd0;
      o_Overrun    <= 1'b0;
    end else begin
      lc_prev_q <= i_LineComplete;
      o_Valid   <= 1'b0;
      o_Overrun <= rise_s && (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            words_q     <= {i_EValue, i_ZValue, i_YValue, i_XValue, i_FValue};
            dir_q       <= {i_EDirection, i_ZDirection, i_YDirection, i_XDirection};
            byte_idx_q  <= 3'd0;
            field_idx_q <= FIELD_F;
            acc_q       <= 32'd0;
            frac_cnt_q  <= 2'd0;
            dot_q       <= 1'b0;
            err_q       <= 1'b0;
            o_Busy      <= 1'b1;
            state_q     <= ST_SCAN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          acc_q      <= acc_d;
          frac_cnt_q <= frac_cnt_d;
          dot_q      <= dot_d;
          err_q      <= err_d;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_q <= 3'd0;
            state_q    <= ST_SCALE;
          end else begin
            byte_idx_q <= byte_idx_q + 3'd1;
          end
        end
        ST_SCALE: begin
          acc_q      <= 32'd0;
          frac_cnt_q <= 2'd0;
          dot_q      <= 1'b0;
          err_q      <= 1'b0;
          if (field_idx_q == FIELD_E) begin
            // E is scaled on the publish edge itself, so it bypasses the shadows
            o_FFixed     <= shadow_q[0];
            o_XFixed     <= shadow_q[1];
            o_YFixed     <= shadow_q[2];
            o_ZFixed     <= shadow_q[3];
            o_EFixed     <= scaled_s;
            o_XDirection <= dir_q[0];
            o_YDirection <= dir_q[1];
            o_ZDirection <= dir_q[2];
            o_EDirection <= dir_q[3];
            o_Error      <= {err_q, shadow_err_q};
            o_Valid      <= 1'b1;
            o_Busy       <= 1'b0;
            field_idx_q  <= FIELD_F;
            state_q      <= ST_IDLE;
          end else begin
            shadow_q[field_idx_q[1:0]]     <= scaled_s;
            shadow_err_q[field_idx_q[1:0]] <= err_q;
            field_idx_q <= field_idx_q + 3'd1;
            state_q     <= ST_SCAN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_g_code_value_converter.sv
// Randomized self-checking bench: two converter builds (FRAC_DIGITS 3 and 0)
// share stimulus and are compared every cycle against a string-level model.
module tb_g_code_value_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lc  = 1'b0;
  logic [47:0] w_f = 48'd0, w_x = 48'd0, w_y = 48'd0, w_z = 48'd0, w_e = 48'd0;
  logic [3:0]  dirs = 4'd0;

  logic [31:0] a_f, a_x, a_y, a_z, a_e, b_f, b_x, b_y, b_z, b_e;
  logic        a_dx, a_dy, a_dz, a_de, b_dx, b_dy, b_dz, b_de;
  logic        a_v, a_b, a_o, b_v, b_b, b_o;
  logic [4:0]  a_err, b_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #10 clk = ~clk;

  g_code_value_converter #(.FRAC_DIGITS(3)) dut (
    .i_Clock50MHz(clk), .i_Reset(rst), .i_LineComplete(lc),
    .i_FValue(w_f), .i_XValue(w_x), .i_YValue(w_y), .i_ZValue(w_z), .i_EValue(w_e),
    .i_XDirection(dirs[0]), .i_YDirection(dirs[1]), .i_ZDirection(dirs[2]), .i_EDirection(dirs[3]),
    .o_FFixed(a_f), .o_XFixed(a_x), .o_YFixed(a_y), .o_ZFixed(a_z), .o_EFixed(a_e),
    .o_XDirection(a_dx), .o_YDirection(a_dy), .o_ZDirection(a_dz), .o_EDirection(a_de),
    .o_Valid(a_v), .o_Busy(a_b), .o_Error(a_err), .o_Overrun(a_o)
  );

  g_code_value_converter #(.FRAC_DIGITS(0)) dut0 (
    .i_Clock50MHz(clk), .i_Reset(rst), .i_LineComplete(lc),
    .i_FValue(w_f), .i_XValue(w_x), .i_YValue(w_y), .i_ZValue(w_z), .i_EValue(w_e),
    .i_XDirection(dirs[0]), .i_YDirection(dirs[1]), .i_ZDirection(dirs[2]), .i_EDirection(dirs[3]),
    .o_FFixed(b_f), .o_XFixed(b_x), .o_YFixed(b_y), .o_ZFixed(b_z), .o_EFixed(b_e),
    .o_XDirection(b_dx), .o_YDirection(b_dy), .o_ZDirection(b_dz), .o_EDirection(b_de),
    .o_Valid(b_v), .o_Busy(b_b), .o_Error(b_err), .o_Overrun(b_o)
  );

  // Text-level conversion: integer part, then the first `frac` fraction digits
  function automatic void ref_convert(input logic [47:0] w, input int frac,
                                      output logic [31:0] val, output logic err);
    longint ip = 0;
    longint fp = 0;
    int     nf = 0;
    int     dots = 0;
    bit     bad = 1'b0;
    logic [7:0] c;
    for (int i = 5; i >= 0; i--) begin
      c = w[i*8 +: 8];
      if (c == 8'd0) continue;
      if (c >= 8'd48 && c <= 8'd57) begin
        if (dots == 0) ip = ip * 10 + longint'(c - 8'd48);
        else if (nf < frac) begin fp = fp * 10 + longint'(c - 8'd48); nf++; end
      end else if (c == 8'd46) begin
        dots++;
        if (dots > 1) bad = 1'b1;
      end else begin
        bad = 1'b1;
      end
    end
    while (nf < frac) begin fp = fp * 10; nf++; end
    err = bad;
    val = bad ? 32'd0 : 32'(ip * (frac == 3 ? 1000 : frac == 2 ? 100 : frac == 1 ? 10 : 1) + fp);
  endfunction

  function automatic logic [47:0] pack(input string s);
    logic [47:0] w = 48'd0;
    for (int i = 0; i < s.len(); i++) w = {w[39:0], s[i]};
    return w;
  endfunction

  // Model state: what each build's outputs must show after every edge
  logic [31:0] e_val [2][5];
  logic [31:0] p_val [2][5];
  logic [4:0]  e_err [2];
  logic [4:0]  p_err [2];
  logic [3:0]  e_dir = 4'd0, p_dir = 4'd0;
  logic        e_valid = 1'b0, e_busy = 1'b0, e_ovr = 1'b0, m_prev = 1'b0;
  int          m_cnt = 0;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int f = 0; f < 5; f++) begin e_val[k][f] = 32'd0; p_val[k][f] = 32'd0; end
      e_err[k] = 5'd0; p_err[k] = 5'd0;
    end
    e_dir = 4'd0; p_dir = 4'd0; e_valid = 1'b0; e_busy = 1'b0; e_ovr = 1'b0;
    m_prev = 1'b0; m_cnt = 0;
  endtask

  initial begin
    logic rise;
    logic [47:0] wl [5];
    model_clear();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_clear();
      end else begin
        rise = lc && !m_prev;
        m_prev = lc;
        e_valid = 1'b0;
        e_ovr = 1'b0;
        if (m_cnt > 0) begin
          e_ovr = rise;
          m_cnt--;
          if (m_cnt == 0) begin
            e_val = p_val; e_err = p_err; e_dir = p_dir; e_valid = 1'b1;
          end
        end else if (rise) begin
          wl[0] = w_f; wl[1] = w_x; wl[2] = w_y; wl[3] = w_z; wl[4] = w_e;
          for (int k = 0; k < 2; k++)
            for (int f = 0; f < 5; f++) ref_convert(wl[f], (k == 0) ? 3 : 0, p_val[k][f], p_err[k][f]);
          p_dir = dirs;
          m_cnt = 35;
        end
        e_busy = (m_cnt > 0);
      end
    end
  end

  task automatic cmp_inst(input int k, input logic [31:0] f, x, y, z, e, input logic [3:0] d,
                          input logic v, b, o, input logic [4:0] er);
    n_cmp++;
    if (f !== e_val[k][0] || x !== e_val[k][1] || y !== e_val[k][2] || z !== e_val[k][3] ||
        e !== e_val[k][4] || d !== e_dir || v !== e_valid || b !== e_busy || o !== e_ovr || er !== e_err[k]) begin
      n_bad++;
      $display("FAIL cycle_check build%0d t=%0t got F=%0d X=%0d Y=%0d Z=%0d E=%0d dir=%b v=%b busy=%b ovr=%b err=%b | want F=%0d X=%0d Y=%0d Z=%0d E=%0d dir=%b v=%b busy=%b ovr=%b err=%b",
               k, $time, f, x, y, z, e, d, v, b, o, er, e_val[k][0], e_val[k][1], e_val[k][2],
               e_val[k][3], e_val[k][4], e_dir, e_valid, e_busy, e_ovr, e_err[k]);
    end
  endtask

  // Per-cycle comparison of both builds against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp_inst(0, a_f, a_x, a_y, a_z, a_e, {a_de, a_dz, a_dy, a_dx}, a_v, a_b, a_o, a_err);
        cmp_inst(1, b_f, b_x, b_y, b_z, b_e, {b_de, b_dz, b_dy, b_dx}, b_v, b_b, b_o, b_err);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic set_words(input string f, x, y, z, e, input logic [3:0] d);
    w_f = pack(f); w_x = pack(x); w_y = pack(y); w_z = pack(z); w_e = pack(e); dirs = d;
  endtask

  // Pulse line-complete for 3 cycles and wait (bounded) for the result strobe
  task automatic run_line(output int lat);
    lat = 0;
    @(negedge clk);
    lc = 1'b1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 3) lc = 1'b0;
      if (a_v) begin lat = n; break; end
    end
    lc = 1'b0;
    if (lat == 0) begin
      n_bad++;
      $display("FAIL valid_timeout got=none want=strobe within 80 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [47:0] rand_word();
    logic [47:0] w = 48'd0;
    logic [7:0]  c;
    int len = $urandom_range(0, 6);
    for (int i = 0; i < len; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 72)      c = 8'd48 + 8'($urandom_range(0, 9));
      else if (r < 86) c = 8'd46;
      else if (r < 90) c = 8'd32;
      else if (r < 94) c = 8'd45;
      else             c = 8'd65 + 8'($urandom_range(0, 25));
      w = {w[39:0], c};
    end
    return w;
  endfunction

  initial begin
    int lat, vcnt, ocnt;
    logic [31:0] mv;
    logic me;

    // Pin the model with hand-computed values
    ref_convert(pack("12.5"), 3, mv, me);   chk("model_12.5", mv, 12500);
    ref_convert(pack("1.2345"), 3, mv, me); chk("model_1.2345", mv, 1234);
    ref_convert(pack("99.9"), 0, mv, me);   chk("model_99.9_f0", mv, 99);
    ref_convert(pack("1..2"), 3, mv, me);   chk("model_1..2_err", {31'd0, me}, 1);

    #5 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_outputs", {a_x, a_f, a_v, a_b, a_err, a_o}, 0);

    set_words("1500", "12.5", "", "", "", 4'b0001);
    run_line(lat);
    chk("latency", lat, 36);
    chk("t1_x", a_x, 12500);
    chk("t1_f", a_f, 1500000);
    chk("t1_xdir", a_dx, 1);
    chk("t1_f0_x", b_x, 12);

    set_words("", "", "1.2345", "0.05", ".", 4'b0000);
    run_line(lat);
    chk("t2_y", a_y, 1234);
    chk("t2_z", a_z, 50);
    chk("t2_e_err", {a_e, a_err}, 0);

    set_words("300", "12A4", "", "", "1..2", 4'b0000);
    run_line(lat);
    chk("t3_err", a_err, 5'b10010);
    chk("t3_f", a_f, 300000);
    chk("t3_x", a_x, 0);

    // Second rising edge while busy
    set_words("", "42", "", "", "", 4'b0010);
    vcnt = 0; ocnt = 0;
    @(negedge clk);
    lc = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 3) lc = 1'b0;
      if (i == 5) w_x = pack("999");
      if (i == 10) lc = 1'b1;
      if (i == 13) lc = 1'b0;
      if (a_v) vcnt++;
      if (a_o) ocnt++;
    end
    chk("ovr_pulses", ocnt, 1);
    chk("ovr_valids", vcnt, 1);
    chk("ovr_x", a_x, 42000);

    // Reset in the middle of a conversion
    set_words("", "5", "", "", "", 4'b1111);
    @(negedge clk);
    lc = 1'b1;
    repeat (20) @(negedge clk);
    lc = 1'b0;
    #2 rst = 1'b1;
    #1 chk("midreset_zero", {a_f, a_x, a_y, a_z, a_e, a_dx, a_dy, a_dz, a_de, a_v, a_b, a_err, a_o}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_words("", "7", "", "", "", 4'b0000);
    run_line(lat);
    chk("after_reset_x", a_x, 7000);
    chk("after_reset_f0_x", b_x, 7);

    // Held line-complete must give exactly one result
    set_words("", "99.9", "", "", "", 4'b0000);
    vcnt = 0;
    @(negedge clk);
    lc = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_v) vcnt++;
    end
    lc = 1'b0;
    chk("held_lc_valids", vcnt, 1);
    chk("f0_x_99.9", b_x, 99);
    repeat (3) @(negedge clk);

    // Random lines, some arriving while busy
    for (int it = 0; it < 60; it++) begin
      w_f = rand_word(); w_x = rand_word(); w_y = rand_word(); w_z = rand_word(); w_e = rand_word();
      dirs = 4'($urandom_range(0, 15));
      lc = 1'b1;
      repeat ($urandom_range(1, 50)) @(negedge clk);
      lc = 1'b0;
      repeat ($urandom_range(1, 45)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
